// File: rtl/scan_pkg.sv
// Shared scan state encoding and index limits for the LED scan controller.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } scan_state_t;

  localparam logic [2:0] IDX_MIN = 3'd0;
  localparam logic [2:0] IDX_MAX = 3'd7;

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: counts 0..DIV-1 while enabled and flags the terminal count.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // clr wins over a coincident terminal count so a stop never produces a step
  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// LED scan controller driving a 3-to-8 decoder select with start/stop/pause control.
// Define SCAN_PINGPONG_EN to bounce 0..7..0 instead of wrapping modulo 8.
module led_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       dir,
  output logic [2:0] A_3,
  output logic       active,
  output logic       wrap
);

  scan_state_t state, state_nxt;
  logic        tick;
  logic [2:0]  idx_nxt;
  logic        wrap_nxt;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == RUN && !pause),
    .clr   (stop || state == IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (pause) state_nxt = HOLD;
        HOLD:    if (!pause) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef SCAN_PINGPONG_EN
  logic dir_q;
  logic dir_flip;

  // Direction reverses at the endpoint itself, so each endpoint is visited once
  always_comb begin
    idx_nxt  = A_3;
    dir_flip = 1'b0;
    if (!dir_q) begin
      if (A_3 == IDX_MAX) begin
        idx_nxt  = A_3 - 3'd1;
        dir_flip = 1'b1;
      end else begin
        idx_nxt = A_3 + 3'd1;
      end
    end else begin
      if (A_3 == IDX_MIN) begin
        idx_nxt  = A_3 + 3'd1;
        dir_flip = 1'b1;
      end else begin
        idx_nxt = A_3 - 3'd1;
      end
    end
    wrap_nxt = (idx_nxt == IDX_MAX) || (idx_nxt == IDX_MIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= 1'b0;
    end else if (state == IDLE && start && !stop) begin
      dir_q <= dir;
    end else if (tick && dir_flip) begin
      dir_q <= ~dir_q;
    end
  end
`else
  always_comb begin
    idx_nxt  = dir ? A_3 - 3'd1 : A_3 + 3'd1;
    wrap_nxt = (A_3 == IDX_MAX && idx_nxt == IDX_MIN) ||
               (A_3 == IDX_MIN && idx_nxt == IDX_MAX);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      A_3    <= IDX_MIN;
      active <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      state  <= state_nxt;
      active <= (state_nxt != IDLE);
      wrap   <= 1'b0;
      if (state_nxt == IDLE) begin
        A_3 <= IDX_MIN;
      end else if (tick) begin
        A_3  <= idx_nxt;
        wrap <= wrap_nxt;
      end
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Scoreboard bench for led_scan_ctrl: a cycle-level reference model predicts outputs.
module tb_led_scan_ctrl;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       dir = 1'b0;
  logic [2:0] A_3;
  logic       active;
  logic       wrap;

  led_scan_ctrl #(.DIV(DIV)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .stop   (stop),
    .pause  (pause),
    .dir    (dir),
    .A_3    (A_3),
    .active (active),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned a3;
    bit          wrap;
    bit          active;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: mode 0=idle 1=running 2=held; phase counts unpaused run cycles
  int m_mode = 0;
  int m_phase = 0;
  int m_idx = 0;
  int m_dirq = 0;

  task automatic model_reset();
    m_mode = 0;
    m_phase = 0;
    m_idx = 0;
    m_dirq = 0;
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, want);
    end
  endtask

  task automatic cycle(input bit s, input bit p, input bit ps, input bit d);
    exp_t e;
    bit   w;
    @(negedge clk);
    start = s;
    stop  = p;
    pause = ps;
    dir   = d;
    w = 0;
    if (p) begin
      m_mode = 0;
      m_phase = 0;
      m_idx = 0;
    end else if (m_mode == 0) begin
      if (s) begin
        m_mode = 1;
        m_phase = 0;
        m_dirq = d;
      end
    end else begin
      if (m_mode == 1 && !ps) begin
        m_phase++;
        if (m_phase == int'(DIV)) begin
          int prev;
          m_phase = 0;
          prev = m_idx;
`ifdef SCAN_PINGPONG_EN
          if (m_dirq == 0) begin
            if (m_idx == 7) begin m_idx = 6; m_dirq = 1; end
            else m_idx = m_idx + 1;
          end else begin
            if (m_idx == 0) begin m_idx = 1; m_dirq = 0; end
            else m_idx = m_idx - 1;
          end
          w = (m_idx == 0) || (m_idx == 7);
`else
          m_idx = d ? (m_idx + 7) % 8 : (m_idx + 1) % 8;
          w = (prev == 7 && m_idx == 0) || (prev == 0 && m_idx == 7);
`endif
        end
      end
      m_mode = ps ? 2 : 1;
    end
    e.a3 = m_idx;
    e.wrap = w;
    e.active = (m_mode != 0);
    exp_q.push_back(e);
  endtask

  // Monitor: compares each registered output set one step after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("a3", int'(A_3), int'(e.a3));
        check("wrap", int'(wrap), int'(e.wrap));
        check("active", int'(active), int'(e.active));
      end
    end
  end

  initial begin
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("reset_a3", int'(A_3), 0);
    check("reset_active", int'(active), 0);
    check("reset_wrap", int'(wrap), 0);
    rst_n = 1'b1;

    // Forward scan through a full wrap
    cycle(1, 0, 0, 0);
    repeat (8 * DIV + 6) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);

    // Reverse scan from idle: first step wraps 0 to 7
    cycle(1, 0, 0, 1);
    repeat (3 * DIV + 2) cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 1);

    // Pause for 10 cycles with the prescaler mid-step
    cycle(1, 0, 0, 0);
    repeat (DIV + 2) cycle(0, 0, 0, 0);
    repeat (10) cycle(0, 0, 1, 0);
    repeat (2 * DIV) cycle(0, 0, 0, 0);

    // Start with pause in the same cycle, then release
    cycle(0, 1, 0, 0);
    cycle(1, 0, 1, 0);
    repeat (4) cycle(0, 0, 1, 0);
    repeat (DIV + 1) cycle(0, 0, 0, 0);

    // Start and stop together from idle
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    repeat (DIV + 1) cycle(0, 0, 0, 0);

    // Stop landing on a tick cycle
    cycle(1, 0, 0, 0);
    repeat (DIV - 1) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);

    // Async reset while A_3 is 5
    cycle(1, 0, 0, 0);
    n = 0;
    while (m_idx != 5 && n < 100) begin
      cycle(0, 0, 0, 0);
      n++;
    end
    check("reach_idx5", m_idx, 5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_a3", int'(A_3), 0);
    check("rst_active", int'(active), 0);
    check("rst_wrap", int'(wrap), 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    model_reset();
    rst_n = 1'b1;
    repeat (2 * DIV + 2) cycle(0, 0, 0, 0);

    // Randomised control traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
